icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache that serves the fetch stage's instruction requests.
- Fetch side: a PC-indexed lookup with a combinational ready/instruction return, so fetch can latch on the same cycle.
- On a miss, a fill FSM requests a whole line from the memory side and loads it beat by beat; fetch sees out_ready=0 until the fill completes.
- Addresses are instruction (word) indices, matching fetch's PC+1 stepping.

Parameters:
- ADDRESS_WIDTH, 64, width of instruction-index address.
- INSTRUCTION_WIDTH, 32, instruction and memory beat width.
- LINES, 16, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, instructions per line (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_enable  in  1  fetch lookup request valid.
- in_addr  in  ADDRESS_WIDTH  instruction index requested.
- in_flush  in  1  invalidate all lines.
- out_ready  out  1  out_instruction_bits valid for in_addr this cycle (hit).
- out_instruction_bits  out  INSTRUCTION_WIDTH  instruction at in_addr; 0 when out_ready=0.
- out_mem_req  out  1  line fill request, held until granted.
- out_mem_addr  out  ADDRESS_WIDTH  line-aligned instruction index (offset bits = 0).
- in_mem_gnt  in  1  memory accepts request this cycle.
- in_mem_valid  in  1  fill beat valid.
- in_mem_data  in  INSTRUCTION_WIDTH  fill beat; beats arrive in ascending word order.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) LSBs.
  - IDX = next log2(LINES) bits.
  - TAG = remaining upper bits.
- Storage: per line, a valid bit, a TAG and WORDS_PER_LINE data words.
- Hit = state IDLE && in_enable && valid[IDX] && tag[IDX]==TAG && !in_flush.
  - out_ready = hit, combinational, zero-cycle latency.
  - out_instruction_bits = data[IDX][OFF] on a hit, else 0.
- FSM states: IDLE, REQ, FILL.
  - IDLE: if in_enable && !hit && !in_flush, latch line address (in_addr with OFF cleared); next state REQ.
  - REQ: out_mem_req=1, out_mem_addr=latched address. On in_mem_gnt go to FILL and clear beat counter. in_mem_valid is ignored in REQ.
  - FILL: each in_mem_valid writes in_mem_data to data[latched IDX][counter], then counter++.
    - On the last beat (counter==WORDS_PER_LINE-1): write the tag, set valid, go to IDLE.
    - Cycles without in_mem_valid hold the current state.
- Miss latency: a hit is available in the first IDLE cycle after the last beat. With immediate grant and back-to-back beats, that is a total of WORDS_PER_LINE+2 cycles from the miss cycle to the out_ready cycle.
- out_ready=0 in REQ and FILL regardless of in_addr.
- A change of in_addr during REQ/FILL does not abort the fill. The new address is evaluated on return to IDLE (it may miss again).
- Refill overwrites the line: the old valid bit is cleared at the FILL entry, so a partially filled line never hits.
- in_mem_valid in IDLE is ignored. out_mem_req stays high until in_mem_gnt.
- Flush:
  - In IDLE: all valid bits clear at the next edge; out_ready=0 in the flush cycle; no miss is started that cycle.
  - In REQ/FILL: a pending-flush flag is set. The fill completes; then all valid bits clear on the transition to IDLE, including the just-filled line.
- Reset (reset==0 at posedge):
  - state=IDLE, all valid=0, counter=0, pending-flush=0, latched address=0.
  - Outputs: out_mem_req=0, out_mem_addr=0, out_ready=0, out_instruction_bits=0.
  - Reset mid-fill aborts the fill; subsequent in_mem_valid beats are ignored.
  - Data and tag arrays are not reset.
- Address arithmetic is unsigned; a line index wraps naturally modulo LINES.

Test Plan:
- Cold miss, LINES=16, WORDS=4: reset, then in_enable=1, in_addr=0x20.
  - Expect out_mem_req=1 with out_mem_addr=0x20.
  - Give a grant, then beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
  - Expect out_ready=1 and bits=0xA0 exactly 6 cycles after the miss cycle.
- Hits within the line after that fill: in_addr=0x21, 0x23.
  - Same-cycle out_ready=1, bits 0xA1 and 0xA3, no out_mem_req.
- Conflict: after filling 0x20, request 0x60 (same IDX, different TAG).
  - Expect a miss and a fill of line 0x60.
  - A re-request of 0x20 then misses again.
- Grant and beat stalls: hold in_mem_gnt=0 for 3 cycles and insert 2 idle cycles between beats.
  - Expect out_mem_req held, out_ready=0 throughout, correct data after the fill.
  - Change in_addr to 0x100 mid-fill; expect a new miss to 0x100 after the fill.
- Flush: assert in_flush during FILL of 0x40.
  - The fill completes, then 0x40 misses.
  - Assert in_flush in IDLE after a hit on 0x20: out_ready=0 that cycle, and 0x20 misses next.
- Reset mid-fill: drive reset=0 after 2 beats of the 0x20 fill, then release.
  - Expect out_mem_req=0; the remaining beats are ignored.
  - 0x20 misses and refills cleanly.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch/memory bus of the instruction cache.
//   slave  : the cache (takes lookups and fill beats, returns hit data and line requests)
//   master : the fetch stage plus memory agent driving the cache
//   in_enable/in_addr/in_flush          fetch lookup and invalidate-all
//   out_ready/out_instruction_bits      same-cycle hit result
//   out_mem_req/out_mem_addr/in_mem_gnt line request handshake
//   in_mem_valid/in_mem_data            fill beats, ascending word order
interface icache_responder_if #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic                         in_enable;
  logic [ADDRESS_WIDTH-1:0]     in_addr;
  logic                         in_flush;
  logic                         out_ready;
  logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits;
  logic                         out_mem_req;
  logic [ADDRESS_WIDTH-1:0]     out_mem_addr;
  logic                         in_mem_gnt;
  logic                         in_mem_valid;
  logic [INSTRUCTION_WIDTH-1:0] in_mem_data;

  modport slave (
    input  in_enable, in_addr, in_flush, in_mem_gnt, in_mem_valid, in_mem_data,
    output out_ready, out_instruction_bits, out_mem_req, out_mem_addr
  );

  modport master (
    output in_enable, in_addr, in_flush, in_mem_gnt, in_mem_valid, in_mem_data,
    input  out_ready, out_instruction_bits, out_mem_req, out_mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache for the fetch stage.
// Addresses are instruction (word) indices: {TAG, IDX, OFF}.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   bus   - icache_responder_if.slave (lookup, flush, line request, fill beats)
// Lookup is combinational: out_ready/out_instruction_bits answer in_addr in the
// same cycle. A miss starts a line fill (IDLE -> REQ -> FILL -> IDLE); lookups
// return out_ready=0 until the fill has written the whole line.
module icache_responder #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int LINES             = 16,
  parameter int WORDS_PER_LINE    = 4
) (
  input  logic               clk,
  input  logic               reset,
  icache_responder_if.slave  bus
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDRESS_WIDTH - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                                            state;
  logic [LINES-1:0]                                  valid;
  logic [TAG_W-1:0]                                  tag_q  [LINES];
  logic [WORDS_PER_LINE-1:0][INSTRUCTION_WIDTH-1:0]  data_q [LINES];
  logic [OFF_W-1:0]                                  cnt;
  logic                                              pend_flush;
  logic                                              mem_req;
  logic [ADDRESS_WIDTH-1:0]                          line_addr;

  logic [OFF_W-1:0] a_off;
  logic [IDX_W-1:0] a_idx, f_idx;
  logic [TAG_W-1:0] a_tag, f_tag;
  logic             hit, last_beat;

  assign a_off = bus.in_addr[OFF_W-1:0];
  assign a_idx = bus.in_addr[OFF_W +: IDX_W];
  assign a_tag = bus.in_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign f_idx = line_addr[OFF_W +: IDX_W];
  assign f_tag = line_addr[ADDRESS_WIDTH-1 -: TAG_W];

  assign hit = (state == IDLE) && bus.in_enable && valid[a_idx] &&
               (tag_q[a_idx] == a_tag) && !bus.in_flush;
  assign last_beat = (state == FILL) && bus.in_mem_valid && (cnt == LAST_OFF);

  assign bus.out_ready            = hit;
  assign bus.out_instruction_bits = hit ? data_q[a_idx][a_off] : '0;
  assign bus.out_mem_req          = mem_req;
  assign bus.out_mem_addr         = line_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      pend_flush <= 1'b0;
      mem_req    <= 1'b0;
      line_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_flush) begin
            valid <= '0;
          end else if (bus.in_enable && !hit) begin
            line_addr  <= {bus.in_addr[ADDRESS_WIDTH-1:OFF_W], OFF_W'(0)};
            mem_req    <= 1'b1;
            pend_flush <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.in_flush) pend_flush <= 1'b1;
          if (bus.in_mem_gnt) begin
            mem_req      <= 1'b0;
            cnt          <= '0;
            // The line is about to be overwritten; keep it from hitting while partial.
            valid[f_idx] <= 1'b0;
            state        <= FILL;
          end
        end
        FILL: begin
          if (bus.in_flush) pend_flush <= 1'b1;
          if (bus.in_mem_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_OFF) begin
              state      <= IDLE;
              pend_flush <= 1'b0;
              // A flush seen during the fill (or on the last beat) wipes everything,
              // including the line just written.
              if (pend_flush || bus.in_flush) valid <= '0;
              else                            valid[f_idx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits alone decide a hit.
  always_ff @(posedge clk) begin
    if (reset && (state == FILL) && bus.in_mem_valid)
      data_q[f_idx][cnt] <= bus.in_mem_data;
    if (reset && last_beat)
      tag_q[f_idx] <= f_tag;
  end
endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;
  localparam int AW = 64, IW = 32, LINES = 16, W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_responder_if #(.ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) bif ();

  icache_responder #(
    .ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .LINES(LINES), .WORDS_PER_LINE(W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );

  typedef struct {
    logic          rdy;
    logic [IW-1:0] bits;
    logic          req;
    logic [AW-1:0] maddr;
    bit            chk_addr;
  } exp_t;
  exp_t sbq[$];

  int checks = 0, errors = 0;

  // Reference model: cache contents as line addresses, plus one fill record.
  bit            lv [LINES];
  logic [AW-1:0] lt [LINES];
  bit            busy = 0, granted = 0, pend = 0, just_rst = 0;
  logic [AW-1:0] fl = '0;
  int            beats = 0, gcnt = 0, bcnt = 0, ghost = 0;
  int            gdel_cfg = 0, gap_cfg = 0;

  // Inputs currently applied
  bit            rst_v = 0, en_v = 0, fl_v = 0, gnt_v = 0, mv_v = 0;
  logic [AW-1:0] a_v = '0;
  logic [IW-1:0] md_v = '0;

  function automatic logic [IW-1:0] memval(input logic [AW-1:0] a);
    return a[31:0] ^ 32'h80 ^ {a[63:56], 24'h0};
  endfunction
  function automatic int lidx(input logic [AW-1:0] a);
    return int'((a / W) % LINES);
  endfunction
  function automatic logic [AW-1:0] laddr(input logic [AW-1:0] a);
    return a - (a % W);
  endfunction
  function automatic bit mhit(input logic [AW-1:0] a);
    return lv[lidx(a)] && (lt[lidx(a)] === laddr(a));
  endfunction
  function automatic int next_gap();
    if (gap_cfg >= 0) return gap_cfg;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs of the cycle just ended.
  task automatic model_step();
    if (!rst_v) begin
      if (busy && granted) ghost = W - beats;  // memory keeps sending what it owed
      busy = 0; pend = 0; fl = '0; just_rst = 1;
      foreach (lv[i]) lv[i] = 0;
    end else if (!busy) begin
      if (fl_v) foreach (lv[i]) lv[i] = 0;
      else if (en_v && !mhit(a_v)) begin
        busy = 1; granted = 0; fl = laddr(a_v); beats = 0; pend = 0; just_rst = 0;
        gcnt = (gdel_cfg < 0) ? int'($urandom_range(0, 3)) : gdel_cfg;
      end
    end else begin
      if (fl_v) pend = 1;
      if (!granted) begin
        if (gnt_v) begin granted = 1; lv[lidx(fl)] = 0; bcnt = next_gap(); end
      end else if (mv_v) begin
        beats++;
        if (beats == W) begin
          if (pend) foreach (lv[i]) lv[i] = 0;
          else begin lv[lidx(fl)] = 1; lt[lidx(fl)] = fl; end
          busy = 0; pend = 0;
        end else bcnt = next_gap();
      end
    end
  endtask

  // Memory side: grant after a stall, then beats with gaps; junk beats when idle.
  task automatic agent();
    gnt_v = 0; mv_v = 0; md_v = $urandom;
    if (ghost > 0) begin mv_v = 1; ghost--; end
    else if (busy && !granted) begin
      if (gcnt == 0) gnt_v = 1; else gcnt--;
      mv_v = ($urandom_range(0, 3) == 0);
    end else if (busy) begin
      if (bcnt == 0) begin mv_v = 1; md_v = memval(fl + beats); end
      else bcnt--;
    end else mv_v = ($urandom_range(0, 7) == 0);
  endtask

  task automatic cycle(input bit r, input bit e, input bit f, input logic [AW-1:0] a);
    exp_t x;
    @(posedge clk);
    model_step();
    #1;
    rst_v = r; en_v = e; fl_v = f; a_v = a;
    agent();
    reset            = r;
    bif.in_enable    = e;
    bif.in_flush     = f;
    bif.in_addr      = a;
    bif.in_mem_gnt   = gnt_v;
    bif.in_mem_valid = mv_v;
    bif.in_mem_data  = md_v;
    x.rdy      = !busy && en_v && !fl_v && mhit(a_v);
    x.bits     = x.rdy ? memval(a_v) : '0;
    x.req      = busy && !granted;
    x.maddr    = fl;
    x.chk_addr = x.req || just_rst;
    sbq.push_back(x);
  endtask

  // Hold a lookup until the DUT hits; n = cycles before the hit cycle.
  task automatic fetch(input logic [AW-1:0] a, output int n, output logic [IW-1:0] b);
    n = 0; b = '0;
    forever begin
      cycle(1, 1, 0, a);
      #3;
      if (bif.out_ready === 1'b1) begin b = bif.out_instruction_bits; break; end
      n++;
      if (n >= 60) break;
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("out_ready", 64'(bif.out_ready), 64'(e.rdy));
        chk("out_bits", 64'(bif.out_instruction_bits), 64'(e.bits));
        chk("out_mem_req", 64'(bif.out_mem_req), 64'(e.req));
        if (e.chk_addr) chk("out_mem_addr", bif.out_mem_addr, e.maddr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [IW-1:0] b;
    logic [AW-1:0] ra;
    reset = 1'b0;
    bif.in_enable = 0; bif.in_flush = 0; bif.in_addr = '0;
    bif.in_mem_gnt = 0; bif.in_mem_valid = 0; bif.in_mem_data = '0;

    repeat (2) cycle(0, 0, 0, '0);
    gdel_cfg = 0; gap_cfg = 0;

    // Cold miss and same-line hits
    fetch(64'h20, n, b); chk("cold_lat", 64'(n), 6); chk("cold_bits", 64'(b), 64'hA0);
    fetch(64'h21, n, b); chk("hit21_lat", 64'(n), 0); chk("hit21_bits", 64'(b), 64'hA1);
    fetch(64'h23, n, b); chk("hit23_lat", 64'(n), 0); chk("hit23_bits", 64'(b), 64'hA3);

    // Conflict on the same index
    fetch(64'h60, n, b); chk("conf60_lat", 64'(n), 6); chk("conf60_bits", 64'(b), 64'hE0);
    fetch(64'h20, n, b); chk("re20_lat", 64'(n), 6);

    // Grant stall of 3 and 2-cycle beat gaps: 1+3+1+4*3 = 17
    gdel_cfg = 3; gap_cfg = 2;
    fetch(64'h40, n, b); chk("stall_lat", 64'(n), 17); chk("stall_bits", 64'(b), 64'hC0);

    // Address change mid-fill does not abort the fill
    cycle(1, 1, 0, 64'h44);
    repeat (5) cycle(1, 1, 0, 64'h44);
    for (int i = 0; i < 40 && busy; i++) cycle(1, 1, 0, 64'h100);
    fetch(64'h100, n, b); chk("new100_bits", 64'(b), 64'h180);
    fetch(64'h45, n, b); chk("kept44_lat", 64'(n), 0);

    // Flush during a fill: the fill completes, then everything is invalid
    gdel_cfg = 0; gap_cfg = 0;
    cycle(1, 1, 0, 64'h40);
    cycle(1, 1, 0, 64'h40);
    cycle(1, 1, 1, 64'h40);
    for (int i = 0; i < 20 && busy; i++) cycle(1, 0, 0, 64'h40);
    fetch(64'h40, n, b); chk("flfill_lat", 64'(n), 6);
    fetch(64'h20, n, b); chk("flfill20_lat", 64'(n), 6);

    // Flush in IDLE right after a hit
    fetch(64'h20, n, b); chk("prefl_lat", 64'(n), 0);
    cycle(1, 1, 1, 64'h20); #3; chk("idle_flush_rdy", 64'(bif.out_ready), 0);
    fetch(64'h20, n, b); chk("postfl_lat", 64'(n), 6);

    // Reset after two beats of a fill
    cycle(1, 0, 1, '0);
    cycle(1, 1, 0, 64'h20);
    cycle(1, 1, 0, 64'h20);
    cycle(1, 1, 0, 64'h20);
    cycle(1, 1, 0, 64'h20);
    cycle(0, 0, 0, 64'h20);
    repeat (4) begin cycle(1, 0, 0, 64'h20); #3; chk("rst_mem_req", 64'(bif.out_mem_req), 0); end
    fetch(64'h20, n, b); chk("rst_refill_lat", 64'(n), 6); chk("rst_refill_bits", 64'(b), 64'hA0);

    // Randomized traffic
    gdel_cfg = -1; gap_cfg = -1;
    ra = '0;
    for (int i = 0; i < 3000; i++) begin
      bit r, e, f;
      r = ($urandom_range(0, 199) != 0);
      e = r && ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ra = 64'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) ra[63] = 1'b1;
      end
      cycle(r, e, f, ra);
    end
    cycle(1, 0, 0, '0);
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
